div_arbiter: RTL and testbench

//  Sequences and shares the single 32-bit unsigned iterative divider (DIVU) between two

---
 rtl/div_arb_pkg.sv | 19 +
 rtl/div_arbiter_if.sv | 31 +++
 rtl/div_arbiter_divu.sv | 55 +++++
 rtl/div_arbiter.sv | 147 ++++++++++++++
 tb/tb_div_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
// Imported by the arbiter top, the bench and anything binding checkers to the FSM.
package div_arb_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int MAX_WAIT_DEF = 40;
    localparam int ID_W         = 1;

    // Quotient reported when the divisor is zero.
    localparam logic [WIDTH_DEF-1:0] DZ_Q = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/div_arbiter_if.sv
// One requester channel of the divider arbiter: request and response halves.
// Handshake: a request transfers on a cycle where req_valid && req_ready; the
// requester holds operands stable while req_valid && !req_ready and may drop
// req_valid without penalty. A response is held with rsp_valid until a cycle
// where rsp_valid && rsp_ready, and its fields stay stable until then.
interface div_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic [WIDTH-1:0] req_dividend;
    logic [WIDTH-1:0] req_divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_q;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_dz;
    logic             rsp_err;

    modport master (
        output req_valid, req_signed, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_err
    );

    modport slave (
        input  req_valid, req_signed, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_err
    );

endinterface

// File: rtl/div_arbiter_divu.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, busy for
// WIDTH cycles after a start pulse. Divisor must be nonzero.
module div_arbiter_divu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dv;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   trial;

    // Bit WIDTH of the trial difference is set exactly when the shifted remainder is below dv.
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, dv};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem  <= '0;
            quo  <= '0;
            dv   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            quo  <= dividend;
            dv   <= divisor;
            cnt  <= CW'(WIDTH);
            busy <= 1'b1;
        end else if (busy) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) busy <= 1'b0;
        end
    end

    assign q = quo;
    assign r = rem;

endmodule

// File: rtl/div_arbiter.sv
// Shares one unsigned iterative divider between two requesters, round-robin,
// with signed-operand handling and local divide-by-zero resolution.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic         clock,
    input  logic         reset,
    div_arbiter_if.slave ch0,
    div_arbiter_if.slave ch1,
    output state_t       dbg_state,
    output logic         dbg_div_start
);
    localparam int WD_W = $clog2(MAX_WAIT + 2);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_WAIT);

    state_t state, state_nxt;

    logic [ID_W-1:0]  rr, id, gnt_id;
    logic             any_req, rsp_hs;
    logic             sel_signed;
    logic [WIDTH-1:0] sel_dd, sel_dv;
    logic [WIDTH-1:0] mag_dd, mag_dv;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] res_q, res_r;
    logic             res_dz, res_err;
    logic [WD_W-1:0]  wd_cnt;
    logic             wait_done, wd_expired;
    logic             div_start, div_busy;
    logic [WIDTH-1:0] div_q, div_r;

    assign any_req = ch0.req_valid | ch1.req_valid;

    always_comb begin
        if (ch0.req_valid && ch1.req_valid) gnt_id = rr;
        else                                gnt_id = ch1.req_valid ? 1'b1 : 1'b0;
        sel_signed = (gnt_id == 1'b0) ? ch0.req_signed   : ch1.req_signed;
        sel_dd     = (gnt_id == 1'b0) ? ch0.req_dividend : ch1.req_dividend;
        sel_dv     = (gnt_id == 1'b0) ? ch0.req_divisor  : ch1.req_divisor;
    end

    assign rsp_hs     = (id == 1'b0) ? ch0.rsp_ready : ch1.rsp_ready;
    // Busy is not trusted in the first WAIT cycle (wd_cnt == 0).
    assign wait_done  = (wd_cnt != '0) && !div_busy;
    assign wd_expired = wd_cnt > WD_LIMIT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = (sel_dv == '0) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (wait_done || wd_expired) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_hs) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ch0.req_ready = (state == ST_IDLE) && any_req && (gnt_id == 1'b0);
        ch1.req_ready = (state == ST_IDLE) && any_req && (gnt_id == 1'b1);
        ch0.rsp_valid = (state == ST_RESP) && (id == 1'b0);
        ch1.rsp_valid = (state == ST_RESP) && (id == 1'b1);
        div_start     = (state == ST_ISSUE);
        dbg_state     = state;
        dbg_div_start = div_start;
    end

    assign ch0.rsp_q   = res_q;
    assign ch0.rsp_r   = res_r;
    assign ch0.rsp_dz  = res_dz;
    assign ch0.rsp_err = res_err;
    assign ch1.rsp_q   = res_q;
    assign ch1.rsp_r   = res_r;
    assign ch1.rsp_dz  = res_dz;
    assign ch1.rsp_err = res_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr      <= '0;
            id      <= '0;
            mag_dd  <= '0;
            mag_dv  <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            res_q   <= '0;
            res_r   <= '0;
            res_dz  <= 1'b0;
            res_err <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (any_req) begin
                    id     <= gnt_id;
                    rr     <= ~gnt_id;
                    wd_cnt <= '0;
                    neg_q  <= sel_signed & (sel_dd[WIDTH-1] ^ sel_dv[WIDTH-1]);
                    neg_r  <= sel_signed & sel_dd[WIDTH-1];
                    // The most negative value negates to itself and is then read as unsigned.
                    mag_dd <= (sel_signed && sel_dd[WIDTH-1]) ? -sel_dd : sel_dd;
                    mag_dv <= (sel_signed && sel_dv[WIDTH-1]) ? -sel_dv : sel_dv;
                    if (sel_dv == '0) begin
                        res_q   <= WIDTH'(DZ_Q);
                        res_r   <= sel_dd;
                        res_dz  <= 1'b1;
                        res_err <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (wait_done) begin
                        res_q   <= neg_q ? -div_q : div_q;
                        res_r   <= neg_r ? -div_r : div_r;
                        res_dz  <= 1'b0;
                        res_err <= 1'b0;
                    end else if (wd_expired) begin
                        res_dz  <= 1'b0;
                        res_err <= 1'b1;
                    end
                end
                ST_RESP: if (rsp_hs) begin
                    res_dz  <= 1'b0;
                    res_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    div_arbiter_divu #(.WIDTH(WIDTH)) u_divu (
        .clock    (clock),
        .reset    (~reset),
        .start    (div_start),
        .dividend (mag_dd),
        .divisor  (mag_dv),
        .q        (div_q),
        .r        (div_r),
        .busy     (div_busy)
    );

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: drivers per requester, a response
// scoreboard fed at grant time, and directed plus random division cases.
module tb_div_arbiter;
    import div_arb_pkg::*;

    localparam int W     = 32;
    localparam int EXP_W = 1 + W + W + 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    div_arbiter_if #(.WIDTH(W)) ch0 ();
    div_arbiter_if #(.WIDTH(W)) ch1 ();
    state_t dbg_state;
    logic   dbg_div_start;

    div_arbiter #(.WIDTH(W), .MAX_WAIT(40)) dut (
        .clock         (clock),
        .reset         (reset),
        .ch0           (ch0),
        .ch1           (ch1),
        .dbg_state     (dbg_state),
        .dbg_div_start (dbg_div_start)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    logic [EXP_W-1:0] exp_q[$];
    int grant_ids[$];

    task automatic check_eq(input string tag, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: SV signed division truncates toward zero, matching DIV semantics.
    function automatic logic [EXP_W-1:0] model(input int id, input logic sgn,
                                               input logic [W-1:0] dd, input logic [W-1:0] dv);
        logic [W-1:0] q, r;
        logic dz;
        dz = 1'b0;
        if (dv == 0) begin
            q = 32'hFFFF_FFFF; r = dd; dz = 1'b1;
        end else if (sgn) begin
            if (dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'h0;
            end else begin
                q = $signed(dd) / $signed(dv);
                r = $signed(dd) % $signed(dv);
            end
        end else begin
            q = dd / dv; r = dd % dv;
        end
        return {id[0], q, r, dz, 1'b0};
    endfunction

    always @(posedge clock) if (dbg_div_start) start_cnt++;

    task automatic pop_cmp(input int p, input logic [EXP_W-1:0] got);
        if (exp_q.size() == 0) check_eq($sformatf("rsp%0d_unexpected", p), EXP_W'(exp_q.size()), EXP_W'(1));
        else check_eq($sformatf("rsp%0d_result", p), got, exp_q.pop_front());
    endtask

    always @(negedge clock) begin
        if (ch0.rsp_valid && ch0.rsp_ready) pop_cmp(0, {1'b0, ch0.rsp_q, ch0.rsp_r, ch0.rsp_dz, ch0.rsp_err});
        if (ch1.rsp_valid && ch1.rsp_ready) pop_cmp(1, {1'b1, ch1.rsp_q, ch1.rsp_r, ch1.rsp_dz, ch1.rsp_err});
    end

    task automatic set_req(input int id, input logic v, input logic s, input logic [W-1:0] dd, input logic [W-1:0] dv);
        if (id == 0) begin
            ch0.req_valid = v; ch0.req_signed = s; ch0.req_dividend = dd; ch0.req_divisor = dv;
        end else begin
            ch1.req_valid = v; ch1.req_signed = s; ch1.req_dividend = dd; ch1.req_divisor = dv;
        end
    endtask

    function automatic logic get_ready(input int id);
        return (id == 0) ? ch0.req_ready : ch1.req_ready;
    endfunction

    task automatic drive_req(input int id, input logic sgn, input logic [W-1:0] dd, input logic [W-1:0] dv);
        bit done = 0;
        @(posedge clock); #1;
        set_req(id, 1'b1, sgn, dd, dv);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clock);
            if (get_ready(id)) begin
                exp_q.push_back(model(id, sgn, dd, dv));
                grant_ids.push_back(id);
                done = 1;
            end
        end
        if (!done) check_eq($sformatf("req%0d_grant_timeout", id), EXP_W'(get_ready(id)), EXP_W'(1));
        @(posedge clock); #1;
        set_req(id, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && dbg_state == ST_IDLE) done = 1;
        end
        if (!done) check_eq("drain_timeout", EXP_W'(exp_q.size()), EXP_W'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, EXP_W'({ch0.req_ready, ch0.rsp_valid, ch0.rsp_dz, ch0.rsp_err,
                                          ch1.req_ready, ch1.rsp_valid, ch1.rsp_dz, ch1.rsp_err,
                                          dbg_div_start, dbg_state}), EXP_W'(0));
        check_eq({tag, "_qr0"}, EXP_W'({ch0.rsp_q, ch0.rsp_r}), EXP_W'(0));
        check_eq({tag, "_qr1"}, EXP_W'({ch1.rsp_q, ch1.rsp_r}), EXP_W'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        grant_ids.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int s0;
        logic [EXP_W-1:0] snap;
        bit seen;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        ch0.rsp_ready = 1'b1;
        ch1.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;

        // 1) unsigned 10/2 on req0, one divider start
        s0 = start_cnt;
        drive_req(0, 1'b0, 32'h0000_000A, 32'h0000_0002);
        wait_drain();
        check_eq("t1_start_pulses", EXP_W'(start_cnt - s0), EXP_W'(1));

        // 2) signed -20/3 on req1
        drive_req(1, 1'b1, 32'hFFFF_FFEC, 32'h0000_0003);
        wait_drain();

        // 3) simultaneous requests after reset, then round-robin order
        pulse_reset();
        fork
            drive_req(0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
            drive_req(1, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
        join
        wait_drain();
        check_eq("t3_pair1_first", EXP_W'(grant_ids[0]), EXP_W'(0));
        check_eq("t3_pair1_count", EXP_W'(grant_ids.size()), EXP_W'(2));
        drive_req(0, 1'b0, 32'h0000_0064, 32'h0000_0007);
        wait_drain();
        grant_ids.delete();
        fork
            drive_req(0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
            drive_req(1, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
        join
        wait_drain();
        check_eq("t3_pair2_first", EXP_W'(grant_ids[0]), EXP_W'(1));

        // 4) divide by zero, no divider start
        s0 = start_cnt;
        drive_req(0, 1'b0, 32'h0000_0014, 32'h0000_0000);
        wait_drain();
        check_eq("t4_no_start", EXP_W'(start_cnt - s0), EXP_W'(0));
        drive_req(1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0000);
        wait_drain();

        // Signed overflow case
        drive_req(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_drain();

        // 5) reset while waiting on the divider
        drive_req(0, 1'b0, 32'h0000_0064, 32'h0000_0007);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            if (dbg_state == ST_WAIT) seen = 1;
        end
        check_eq("t5_reached_wait", EXP_W'(seen), EXP_W'(1));
        reset = 1'b0;
        #1;
        check_all_zero("t5_mid_reset");
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        drive_req(0, 1'b0, 32'h5555_5555, 32'h7FFF_FFFF);
        wait_drain();

        // 6) back-pressure on rsp0 while req1 waits
        ch0.rsp_ready = 1'b0;
        drive_req(0, 1'b1, 32'hFFFF_FF9C, 32'h0000_0009);
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clock);
            if (ch0.rsp_valid) seen = 1;
        end
        check_eq("t6_rsp0_valid", EXP_W'(seen), EXP_W'(1));
        snap = {1'b0, ch0.rsp_q, ch0.rsp_r, ch0.rsp_dz, ch0.rsp_err};
        fork
            drive_req(1, 1'b0, 32'h0000_1000, 32'h0000_0010);
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clock);
                    check_eq("t6_rsp0_stable", {ch0.rsp_valid, ch0.rsp_q, ch0.rsp_r, ch0.rsp_dz, ch0.rsp_err}, snap | {1'b1, {(EXP_W-1){1'b0}}});
                    check_eq("t6_req1_ready_low", EXP_W'(ch1.req_ready), EXP_W'(0));
                end
                ch0.rsp_ready = 1'b1;
            end
        join
        wait_drain();

        // Random mix of signed/unsigned and occasional zero divisors
        for (int i = 0; i < 12; i++) begin
            int id;
            logic sgn;
            logic [W-1:0] dd, dv;
            id  = $urandom_range(0, 1);
            sgn = 1'($urandom_range(0, 1));
            dd  = $urandom;
            dv  = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
            drive_req(id, sgn, dd, dv);
            wait_drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks done", n_checks);
        $fatal(1, "global timeout");
    end

endmodule
